// File: rtl/ps2_rx_fifo.sv
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 device-to-host receiver with show-ahead scan-code FIFO,
//               frame validation, bit-period timeout and sticky error flags.
//               Optional odd-parity check: define PS2_PARITY_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx_fifo #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int CW             = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    input  logic          rd_pop,
    input  logic          err_clr,
    output logic [7:0]    data,
    output logic          ready,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          frame_err,
    output logic          parity_err
);

    localparam int AW = CW - 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_data   = 2'd1;
    localparam logic [1:0] c_parity = 2'd2;
    localparam logic [1:0] c_stop   = 2'd3;

    logic          r_clk_s1, r_clk_s2, r_clk_prev;
    logic          r_dat_s1, r_dat_s2;
    logic [1:0]    r_state;
    logic [2:0]    r_bitcnt;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_shift;
    logic [CW-1:0] r_wp, r_rp;
    logic [7:0]    r_mem [DEPTH];
    logic          r_overflow, r_frame_err;

    logic w_fall, w_timeout, w_push, w_frame_set;
    logic w_empty, w_full, w_pop, w_wr, w_ovf_set;

    // Pin synchronisers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_timeout = (r_state != c_idle) && (r_tcnt == TW'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
    logic r_par_bit;
    logic r_parity_err;
    logic w_par_set;
    logic w_par_ok;

    assign w_par_ok = ^{r_shift, r_par_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_par_bit <= 1'b0;
        else if (!w_timeout && w_fall && r_state == c_parity)
            r_par_bit <= r_dat_s2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_parity_err <= 1'b0;
        else
            r_parity_err <= w_par_set | (r_parity_err & ~err_clr);
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    // A timeout takes priority over any coincident edge.
    always_comb begin
        w_push      = 1'b0;
        w_frame_set = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        w_par_set   = 1'b0;
`endif
        if (w_timeout) begin
            w_frame_set = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                c_idle: begin
                    if (r_dat_s2)
                        w_frame_set = 1'b1;
                end
                c_stop: begin
                    if (!r_dat_s2)
                        w_frame_set = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    else if (!w_par_ok)
                        w_par_set = 1'b1;
`endif
                    else
                        w_push = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_idle;
            r_bitcnt <= 3'd0;
            r_tcnt   <= '0;
            r_shift  <= 8'h00;
        end else if (w_timeout) begin
            r_state <= c_idle;
            r_tcnt  <= '0;
        end else begin
            if (r_state == c_idle || w_fall)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + TW'(1);

            if (w_fall) begin
                case (r_state)
                    c_idle: begin
                        if (!r_dat_s2) begin
                            r_state  <= c_data;
                            r_bitcnt <= 3'd0;
                        end
                    end
                    c_data: begin
                        r_shift <= {r_dat_s2, r_shift[7:1]};
                        if (r_bitcnt == 3'd7)
                            r_state <= c_parity;
                        else
                            r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    c_parity: r_state <= c_stop;
                    c_stop:   r_state <= c_idle;
                    default:  r_state <= c_idle;
                endcase
            end
        end
    end

    assign w_empty   = (r_wp == r_rp);
    assign w_full    = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    assign w_pop     = rd_pop & ~w_empty;
    // A pop in the same cycle frees the slot the full-FIFO push lands in.
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wp[AW-1:0]] <= r_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + CW'(1);
            if (w_pop)
                r_rp <= r_rp + CW'(1);
            r_overflow  <= w_ovf_set   | (r_overflow  & ~err_clr);
            r_frame_err <= w_frame_set | (r_frame_err & ~err_clr);
        end
    end

    assign data      = w_empty ? 8'h00 : r_mem[r_rp[AW-1:0]];
    assign ready     = ~w_empty;
    assign count     = r_wp - r_rp;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Directed self-checking bench for ps2_rx_fifo (DEPTH=8,
//               TIMEOUT_CYCLES=100). Parity expectations follow
//               PS2_PARITY_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_pop;
    logic       err_clr;
    logic [7:0] data;
    logic       ready;
    logic [3:0] count;
    logic       overflow;
    logic       frame_err;
    logic       parity_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .DEPTH          (8),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_pop     (rd_pop),
        .err_clr    (err_clr),
        .data       (data),
        .ready      (ready),
        .count      (count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // PS/2 half period is 10 clk cycles; data changes while ps2_clk is high.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_clk(10);
            ps2_clk = 1'b0;
            wait_clk(10);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic stop);
        send_bits({stop, (~^b) ^ bad_par, b, 1'b0}, 11);
        ps2_data = 1'b1;
        wait_clk(20);
    endtask

    task automatic pop();
        rd_pop = 1'b1;
        wait_clk(1);
        rd_pop = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_pop   = 1'b0;
        err_clr  = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);

        check("rst_data", data, 8'h00);
        check("rst_ready", ready, 1'b0);
        check("rst_count", count, 4'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);

        // Single byte
        send_byte(8'h1C, 1'b0, 1'b1);
        check("single_ready", ready, 1'b1);
        check("single_data", data, 8'h1C);
        check("single_count", count, 4'd1);
        check("single_flags", {overflow, frame_err, parity_err}, 3'b000);
        pop();
        check("single_pop_ready", ready, 1'b0);
        check("single_pop_data", data, 8'h00);

        // Burst of three
        send_byte(8'hF0, 1'b0, 1'b1);
        send_byte(8'h1C, 1'b0, 1'b1);
        send_byte(8'hE0, 1'b0, 1'b1);
        check("burst_count", count, 4'd3);
        check("burst_pop0", data, 8'hF0);
        pop();
        check("burst_pop1", data, 8'h1C);
        pop();
        check("burst_pop2", data, 8'hE0);
        pop();
        check("burst_empty", ready, 1'b0);

        // Overflow: ninth byte dropped
        for (int i = 1; i <= 9; i++)
            send_byte(8'(i), 1'b0, 1'b1);
        check("ovf_count", count, 4'd8);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_head", data, 8'h01);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_pop%0d", i), data, 32'(i));
            pop();
        end
        check("ovf_drained_count", count, 4'd0);
        check("ovf_drained_ready", ready, 1'b0);
        clear_errors();
        check("ovf_cleared", overflow, 1'b0);

        // Overflow avoided: pop coincides with the ninth push
        for (int i = 1; i <= 8; i++)
            send_byte(8'(i), 1'b0, 1'b1);
        check("copop_full", count, 4'd8);
        send_bits({1'b1, ~^8'h09, 8'h09, 1'b0}, 10);
        ps2_data = 1'b1;
        wait_clk(10);
        ps2_clk = 1'b0;
        wait_clk(2);
        rd_pop = 1'b1;
        wait_clk(1);
        rd_pop = 1'b0;
        wait_clk(7);
        ps2_clk = 1'b1;
        wait_clk(20);
        check("copop_count", count, 4'd8);
        check("copop_overflow", overflow, 1'b0);
        for (int i = 2; i <= 9; i++) begin
            check($sformatf("copop_pop%0d", i), data, 32'(i));
            pop();
        end
        check("copop_drained", count, 4'd0);

        // Bad parity
        send_byte(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err_set", parity_err, 1'b1);
        check("par_count", count, 4'd0);
        clear_errors();
        check("par_err_clr", parity_err, 1'b0);
`else
        check("par_err_off", parity_err, 1'b0);
        check("par_count", count, 4'd1);
        check("par_data", data, 8'h1C);
        pop();
`endif
        check("par_frame_ok", frame_err, 1'b0);

        // Stop bit 0
        send_byte(8'h33, 1'b0, 1'b0);
        check("stop_frame_err", frame_err, 1'b1);
        check("stop_count", count, 4'd0);
        clear_errors();
        check("stop_clr", frame_err, 1'b0);

        // Start bit 1
        send_bits(11'h7FF, 1);
        wait_clk(10);
        check("start_frame_err", frame_err, 1'b1);
        check("start_count", count, 4'd0);
        clear_errors();

        // Timeout after four data bits
        send_bits({2'b11, ~^8'h29, 8'h29, 1'b0}, 5);
        ps2_data = 1'b1;
        wait_clk(80);
        check("to_not_early", frame_err, 1'b0);
        for (int i = 0; i < 30 && !frame_err; i++)
            wait_clk(1);
        check("to_set", frame_err, 1'b1);
        clear_errors();
        send_byte(8'h29, 1'b0, 1'b1);
        check("to_next_count", count, 4'd1);
        check("to_next_data", data, 8'h29);
        check("to_next_flag", frame_err, 1'b0);
        pop();

        // Reset mid-frame with two bytes queued
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b1);
        check("mid_count", count, 4'd2);
        send_bits({1'b1, ~^8'hA5, 8'hA5, 1'b0}, 6);
        rst = 1'b1;
        #1;
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_ready", ready, 1'b0);
        check("mid_rst_count", count, 4'd0);
        check("mid_rst_flags", {overflow, frame_err, parity_err}, 3'b000);
        ps2_data = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);
        send_byte(8'h5A, 1'b0, 1'b1);
        check("post_rst_count", count, 4'd1);
        check("post_rst_data", data, 8'h5A);
        check("post_rst_flags", {overflow, frame_err, parity_err}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
